// File: rtl/pe_gen_pkg.sv
// Shared opcodes, a clog2 helper and config-field layout helpers for the parametrised PE.
package pe_gen_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_MUL   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SHL   = 4'd6;
  localparam logic [3:0] OP_SHR   = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_LT    = 4'd9;
  localparam logic [3:0] OP_EQ    = 4'd10;
  localparam logic [3:0] OP_PASSA = 4'd11;
  localparam logic [3:0] OP_ACC   = 4'd12;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    return result;
  endfunction

  // Config word layout, LSB first: op, sel_a, sel_b, dly_a, dly_b, osel.
  function automatic int sel_a_lsb();
    return 4;
  endfunction

  function automatic int sel_b_lsb(input int sw);
    return 4 + sw;
  endfunction

  function automatic int dly_a_lsb(input int sw);
    return 4 + 2 * sw;
  endfunction

  function automatic int dly_b_lsb(input int sw, input int dw);
    return 4 + 2 * sw + dw;
  endfunction

  function automatic int osel_lsb(input int sw, input int dw);
    return 4 + 2 * sw + 2 * dw;
  endfunction

  function automatic int cfg_bits(input int sw, input int dw, input int nout);
    return osel_lsb(sw, dw) + nout;
  endfunction

endpackage

// File: rtl/pe_delay_line.sv
// Programmable operand delay line: data and valid emerge dly cycles later, dly=0 is a wire.
module pe_delay_line
  import pe_gen_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int DW = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [DW-1:0]    dly,
  input  logic [WIDTH-1:0] in_d,
  input  logic             in_v,
  output logic [WIDTH-1:0] out_d,
  output logic             out_v
);

  logic [WIDTH-1:0] sr_d [1:DEPTH];
  logic             sr_v [1:DEPTH];
  logic [DW-1:0]    eff;

  // Requests beyond the physical depth are clamped to the last tap.
  assign eff = (dly > DW'(DEPTH)) ? DW'(DEPTH) : dly;

  // Shift data every cycle; while flushing, only invalid entries are admitted.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= DEPTH; k++) begin
        sr_d[k] <= '0;
        sr_v[k] <= 1'b0;
      end
    end else begin
      sr_d[1] <= in_d;
      sr_v[1] <= in_v & ~flush;
      for (int k = 2; k <= DEPTH; k++) begin
        sr_d[k] <= sr_d[k-1];
        sr_v[k] <= sr_v[k-1];
      end
    end
  end

  // Tap select; zero delay bypasses the registers entirely.
  always_comb begin
    out_d = in_d;
    out_v = in_v;
    for (int k = 1; k <= DEPTH; k++) begin
      if (eff == DW'(k)) begin
        out_d = sr_d[k];
        out_v = sr_v[k];
      end
    end
  end

endmodule

// File: rtl/pe_block_gen.sv
// Parametrised processing element: selectable operands with delay lines, registered ALU
// with accumulate and feedback, and per-output bypass of the delayed A operand.
module pe_block_gen
  import pe_gen_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NUM_IN      = 4,
  parameter int DELAY_DEPTH = 4,
  parameter int NUM_OUT     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     config_en,
  input  logic                     config_in,
  output logic                     config_out,
  input  logic [NUM_IN*WIDTH-1:0]  in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]       out_valid
);

  localparam int SW       = clog2(NUM_IN + 1);
  localparam int DW       = clog2(DELAY_DEPTH + 1);
  localparam int CFG_BITS = cfg_bits(SW, DW, NUM_OUT);
  localparam int SHW      = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

  logic [CFG_BITS-1:0] cfg;
  logic [3:0]          op;
  logic [SW-1:0]       sel_a, sel_b;
  logic [DW-1:0]       dly_a, dly_b;
  logic [NUM_OUT-1:0]  osel;

  logic [WIDTH-1:0] src_a_d, src_b_d, a_d, b_d, res, alu_q;
  logic             src_a_v, src_b_v, a_v, b_v, res_v, alu_v;

  assign op         = cfg[3:0];
  assign sel_a      = cfg[sel_a_lsb() +: SW];
  assign sel_b      = cfg[sel_b_lsb(SW) +: SW];
  assign dly_a      = cfg[dly_a_lsb(SW) +: DW];
  assign dly_b      = cfg[dly_b_lsb(SW, DW) +: DW];
  assign osel       = cfg[osel_lsb(SW, DW) +: NUM_OUT];
  assign config_out = cfg[0];

  // Serial config chain; the newest bit enters at the MSB and cfg[0] feeds the next PE.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg <= '0;
    end else if (config_en) begin
      cfg <= {config_in, cfg[CFG_BITS-1:1]};
    end
  end

  // Operand sources: an input port, the registered ALU result, or a dead zero.
  always_comb begin
    src_a_d = '0;
    src_a_v = 1'b0;
    src_b_d = '0;
    src_b_v = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel_a == SW'(i)) begin
        src_a_d = in_data[i*WIDTH +: WIDTH];
        src_a_v = in_valid[i];
      end
      if (sel_b == SW'(i)) begin
        src_b_d = in_data[i*WIDTH +: WIDTH];
        src_b_v = in_valid[i];
      end
    end
    if (sel_a == SW'(NUM_IN)) begin
      src_a_d = alu_q;
      src_a_v = alu_v;
    end
    if (sel_b == SW'(NUM_IN)) begin
      src_b_d = alu_q;
      src_b_v = alu_v;
    end
  end

  pe_delay_line #(.WIDTH(WIDTH), .DEPTH(DELAY_DEPTH)) u_dly_a (
    .clk(clk), .reset(reset), .flush(config_en), .dly(dly_a),
    .in_d(src_a_d), .in_v(src_a_v), .out_d(a_d), .out_v(a_v)
  );

  pe_delay_line #(.WIDTH(WIDTH), .DEPTH(DELAY_DEPTH)) u_dly_b (
    .clk(clk), .reset(reset), .flush(config_en), .dly(dly_b),
    .in_d(src_b_d), .in_v(src_b_v), .out_d(b_d), .out_v(b_v)
  );

  // ALU result and its validity; unused opcodes yield an invalid zero.
  always_comb begin
    res   = '0;
    res_v = a_v & b_v;
    case (op)
      OP_ADD:   res = a_d + b_d;
      OP_SUB:   res = a_d - b_d;
      OP_MUL:   res = a_d * b_d;
      OP_AND:   res = a_d & b_d;
      OP_OR:    res = a_d | b_d;
      OP_XOR:   res = a_d ^ b_d;
      OP_SHL:   res = a_d << b_d[SHW-1:0];
      OP_SHR:   res = a_d >> b_d[SHW-1:0];
      OP_SRA:   res = $signed(a_d) >>> b_d[SHW-1:0];
      OP_LT:    res = WIDTH'($signed(a_d) < $signed(b_d));
      OP_EQ:    res = WIDTH'(a_d == b_d);
      OP_PASSA: begin
        res   = a_d;
        res_v = a_v;
      end
      OP_ACC:   begin
        res   = alu_q + a_d;
        res_v = a_v;
      end
      default:  res_v = 1'b0;
    endcase
  end

  // Result register: holds on invalid cycles, and configuration restarts the accumulator.
  always_ff @(posedge clk) begin
    if (reset || config_en) begin
      alu_q <= '0;
      alu_v <= 1'b0;
    end else begin
      alu_v <= res_v;
      if (res_v) begin
        alu_q <= res;
      end
    end
  end

  // Output steering: registered result or the delayed A operand straight from its line.
  always_comb begin
    out_data  = '0;
    out_valid = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      if (osel[j]) begin
        out_data[j*WIDTH +: WIDTH] = a_d;
        out_valid[j]               = a_v;
      end else begin
        out_data[j*WIDTH +: WIDTH] = alu_q;
        out_valid[j]               = alu_v;
      end
    end
  end

endmodule

// File: doc/pe_block_gen.md
Name: pe_block_gen

Overview:
- Parametrised successor of the fixed two-input ALU/MEM processing element.
- NUM_IN data inputs with valid bits feed a config-selected two-operand ALU. Each operand has its own programmable delay line for schedule alignment.
- The ALU result is registered, has an accumulate mode, and has a feedback path. NUM_OUT outputs each select between the ALU result and the delayed operand A.
- Configuration is a serial shift chain in the single clock domain, cascaded PE to PE through config_in/config_out.

Parameters:
- WIDTH, 32, datapath width.
- NUM_IN, 4, number of data input ports.
- DELAY_DEPTH, 4, maximum programmable operand delay in cycles.
- NUM_OUT, 2, number of data output ports.
- Derived (localparam, not overridable): SW=clog2(NUM_IN+1), DW=clog2(DELAY_DEPTH+1), CFG_BITS=4+2*SW+2*DW+NUM_OUT.

Ports:
- clk  in  1  single clock for data and config.
- reset  in  1  synchronous, active-high.
- config_en  in  1  when 1, the config chain shifts one bit per cycle.
- config_in  in  1  serial config input.
- config_out  out  1  serial config output (cfg[0]), chained to the next PE.
- in_data  in  NUM_IN*WIDTH  packed inputs; in i is [i*WIDTH +: WIDTH].
- in_valid  in  NUM_IN  per-input valid.
- out_data  out  NUM_OUT*WIDTH  packed outputs.
- out_valid  out  NUM_OUT  per-output valid.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high on port "reset".
- Reset clears cfg, both delay lines (data and valid), alu_q, alu_v and the accumulator. Consequences:
  - out_data=0, out_valid=0, config_out=0 on the first edge after reset is sampled.
- Config shift: when config_en=1, cfg <= {config_in, cfg[CFG_BITS-1:1]}. The last bit shifted in lands in the MSB.
- Config fields, LSB first:
  - op[3:0]
  - sel_a[SW], sel_b[SW]
  - dly_a[DW], dly_b[DW]
  - osel[NUM_OUT]
- During config_en=1:
  - delay-line valids shift in 0;
  - alu_v is forced to 0 and alu_q is cleared (accumulator restart);
  - data registers may still shift.
- Source select:
  - sel < NUM_IN selects in_data[sel] with in_valid[sel].
  - sel == NUM_IN selects the feedback alu_q with alu_v.
  - sel > NUM_IN gives data 0, valid 0.
- Delay:
  - operand X (A or B) emerges exactly dly_X cycles after selection; dly_X=0 is combinational passthrough.
  - dly > DELAY_DEPTH clamps to DELAY_DEPTH.
  - Valid travels with data.
- ALU: one registered stage, alu_q/alu_v update every cycle. Opcodes:
  - 0 ADD, 1 SUB (a-b), 2 MUL (low WIDTH bits), 3 AND, 4 OR, 5 XOR.
  - 6 SHL, 7 SHR logical, 8 SRA; shift amount is b[clog2(WIDTH)-1:0].
  - 9 LT signed (result 1/0), 10 EQ (result 1/0), 11 PASSA.
  - 12 ACC: alu_q <= alu_q + a when a_v=1, otherwise hold.
  - 13-15 produce 0 with valid 0.
- Valid rules:
  - two-operand ops: alu_v <= a_v & b_v;
  - PASSA and ACC: alu_v <= a_v.
  - When alu_v would be 0, alu_q holds its value, except in ACC mode, where it also holds.
- Latency: input to out_data = dly + 1 cycles when osel=0.
- Outputs:
  - osel[j]=0: out j = alu_q / alu_v.
  - osel[j]=1: out j = delayed operand A / a_v, combinational from the delay line.
- Feedback with dly_a=0 is legal; it is not a combinational loop because it passes through alu_q.
- Reset asserted together with config_en: reset wins.
- Arithmetic wraps modulo 2^WIDTH.

Decomposition:
- Package pe_gen_pkg holds:
  - opcode localparams (OP_ADD..OP_ACC);
  - a clog2 function;
  - functions computing the config field offsets from the parameters.
- One sub-module, pe_delay_line (params WIDTH, DEPTH; ports clk, reset, flush, dly, in_d, in_v, out_d, out_v), instantiated twice.
- The ALU stays inline.

Test Plan:
- Reset and config: assert reset, shift in 18 bits for op=ADD, sel_a=0, sel_b=1, dly=0, osel=00 -> out_valid=00 throughout configuration; cfg matches the pattern; config_out replays bits shifted in 18 cycles earlier.
- ADD latency: in0=5, in1=7, both valid at cycle t -> out0=out1=12 with valid at t+1; the next cycle with inputs invalid -> valid 0, data held at 12.
- Delay alignment: dly_a=3, dly_b=0, SUB; in0=100 valid at t, in1=40 valid at t+3 -> out0=60 valid at t+4 only. Also set dly_a=7 -> behaves as a delay of 4.
- Accumulate: op=ACC, sel_a=2; in2 = 1,2,3,4 valid on 4 consecutive cycles -> out0 = 1,3,6,10. Then pulse config_en for 1 cycle -> out_valid=0 and the accumulator restarts from 0.
- Feedback/bypass: sel_a=4 (feedback), sel_b=0, ADD, osel=10; seed alu_q=1 and hold in0=1 valid -> out0 increments by 1 per cycle; out1 tracks the operand-A (feedback) value.
- Edge ops: SRA with a=0x80000000, b=4 -> 0xF8000000. LT with a=-1, b=0 -> 1. Opcode 14 -> out_valid=0. sel_a=6 -> out_valid=0.
